osc_freq_meter: RTL



---
 rtl/osc_meter_pkg.sv | 21 ++
 rtl/osc_sync_edge.sv | 27 ++
 rtl/osc_freq_meter.sv | 97 +++++++++
 3 files changed

// File: rtl/osc_meter_pkg.sv
// Shared constants, state encoding and sizing helper for the oscillator frequency meter.
package osc_meter_pkg;

    localparam int DEF_CNT_W         = 16;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_MIN_GATE_LOG2 = 4;
    localparam int DEF_GATE_SEL_W    = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ARM  = 2'd1;
    localparam state_t ST_GATE = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // The longest window minus one must fit without wrapping.
    function automatic int win_cnt_w(input int min_gate_log2, input int gate_sel_w);
        return min_gate_log2 + (1 << gate_sel_w) - 1;
    endfunction

endpackage

// File: rtl/osc_sync_edge.sv
// Brings the asynchronous oscillator tap into the clk domain and flags each rising edge.
module osc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic osc_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/osc_freq_meter.sv
// Counts oscillator rising edges over a 2^k-cycle gate window and hands the count over valid/ready.
module osc_freq_meter
    import osc_meter_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int MIN_GATE_LOG2 = DEF_MIN_GATE_LOG2,
    parameter int GATE_SEL_W    = DEF_GATE_SEL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  osc_in,
    input  logic                  start,
    input  logic [GATE_SEL_W-1:0] gate_sel,
    output logic                  busy,
    output logic [CNT_W-1:0]      result,
    output logic                  overflow,
    output logic                  result_valid,
    input  logic                  result_ready
);

    localparam int WIN_W = win_cnt_w(MIN_GATE_LOG2, GATE_SEL_W);
    localparam int ARM_W = $clog2(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES - 1);

    state_t                  state_q;
    logic [GATE_SEL_W-1:0]   gate_sel_q;
    logic [ARM_W-1:0]        arm_q;
    logic [WIN_W-1:0]        win_q;
    logic [CNT_W-1:0]        count_q;
    logic                    ovf_q;
    logic                    rise;

    function automatic logic [WIN_W-1:0] window_last(input logic [GATE_SEL_W-1:0] sel);
        return WIN_W'((64'd1 << (MIN_GATE_LOG2 + int'(sel))) - 64'd1);
    endfunction

    osc_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .osc_in (osc_in),
        .rise   (rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gate_sel_q <= '0;
            arm_q      <= '0;
            win_q      <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_ARM;
                        gate_sel_q <= gate_sel;
                        arm_q      <= ARM_LAST;
                        count_q    <= '0;
                        ovf_q      <= 1'b0;
                    end
                end
                // Let edges already sitting in the synchroniser drain before counting.
                ST_ARM: begin
                    if (arm_q == '0) begin
                        state_q <= ST_GATE;
                        win_q   <= window_last(gate_sel_q);
                    end else begin
                        arm_q <= arm_q - ARM_W'(1);
                    end
                end
                ST_GATE: begin
                    if (rise) begin
                        if (count_q == CNT_MAX) ovf_q <= 1'b1;
                        else                    count_q <= count_q + CNT_W'(1);
                    end
                    if (win_q == '0) state_q <= ST_DONE;
                    else             win_q   <= win_q - WIN_W'(1);
                end
                ST_DONE: begin
                    if (result_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign result_valid = (state_q == ST_DONE);
    assign result       = count_q;
    assign overflow     = ovf_q;

endmodule
